// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier driving a shared 8-bit ALU, one op per cycle.
// Optional overflow tracking is built when ALU_MUL_SEQ_OVF_EN is defined.
module alu_mul_seq #(
  parameter int          WIDTH   = 8,
  parameter logic [3:0]  OP_ADD  = 4'd5,
  parameter logic [3:0]  OP_SHL  = 4'd6,
  parameter logic [3:0]  OP_IDLE = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds its
  // outputs until out_ready is seen.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_added;
  logic [WIDTH-1:0] r_prod;
  logic             w_accept;
  logic             w_do_add;
  logic             w_do_shl;
  logic             w_finish;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign dbg_state = r_state;
  assign out_prod  = r_prod;
  assign out_zero  = (r_prod == '0);

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = OP_IDLE;
    w_do_add  = 1'b0;
    w_do_shl  = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_STEP;
      end
      S_STEP: begin
        if (r_q == '0) begin
          w_finish = 1'b1;
          w_next   = S_DONE;
        end else if (r_q[0] && !r_added) begin
          alu_op   = OP_ADD;
          alu_a    = r_p;
          alu_b    = r_m;
          w_do_add = 1'b1;
        end else begin
          alu_op   = OP_SHL;
          alu_a    = r_m;
          w_do_shl = 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_added <= 1'b0;
      r_prod  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_m     <= in_a;
        r_q     <= in_b;
        r_p     <= '0;
        r_added <= 1'b0;
      end
      if (w_do_add) begin
        r_p     <= alu_out;
        r_added <= 1'b1;
      end
      if (w_do_shl) begin
        r_m     <= alu_out;
        r_q     <= r_q >> 1;
        r_added <= 1'b0;
      end
      // Result is latched once so the outputs stay put after DONE is left.
      if (w_finish) r_prod <= r_p;
    end
  end

`ifdef ALU_MUL_SEQ_OVF_EN
  logic r_ovf;
  logic r_out_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ovf <= 1'b0;
      end else if (w_do_add && (alu_out < r_p)) begin
        r_ovf <= 1'b1;
      end else if (w_do_shl && r_m[WIDTH-1] && ((r_q >> 1) != '0)) begin
        // A bit lost off M still has a pending add ahead of it.
        r_ovf <= 1'b1;
      end
      if (w_finish) r_out_ovf <= r_ovf;
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed plus random bench for alu_mul_seq with a behavioural ALU and result scoreboard.
module tb_alu_mul_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_prod;
  logic       out_zero;
  logic       out_ovf;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ops[64];
  logic [9:0] exp_q[$];

  alu_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // behavioural ALU: 5 = add, 6 = shift A left by 1, anything else yields 0
  always_comb begin
    case (alu_op)
      4'd5:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = {alu_a[6:0], 1'b0};
      default: alu_out = 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_steps(input logic [7:0] b);
    int pc;
    int msb;
    pc  = 0;
    msb = -1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
    return pc + msb + 1 + 1;
  endfunction

  // driver: one full operation, optionally stalling the consumer for `stall` cycles
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
    int cnt;
    int wait_c;
    logic bad_ready;
    logic [15:0] full;
    logic [9:0] e;
    logic exp_ovf;
    wait_c = 0;
    while (!in_ready && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    check("in_ready_idle", in_ready, 1);
    check("alu_op_idle", alu_op, 0);
    full = a * b;
`ifdef ALU_MUL_SEQ_OVF_EN
    exp_ovf = (full > 16'd255);
`else
    exp_ovf = 1'b0;
`endif
    exp_q.push_back({full[7:0], (full[7:0] == 8'd0), exp_ovf});
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid  = 1'b0;
    cnt       = 0;
    bad_ready = 1'b0;
    while (!out_valid && cnt < 40) begin
      ops[cnt] = int'(alu_op);
      if (in_ready) bad_ready = 1'b1;
      cnt++;
      @(negedge clk);
    end
    check("step_cycles", cnt, exp_steps(b));
    check("in_ready_busy", bad_ready, 0);
    check("out_valid_rise", out_valid, 1);
    e = exp_q.pop_front();
    check("out_prod", out_prod, e[9:2]);
    check("out_zero", out_zero, e[1]);
    check("out_ovf", out_ovf, e[0]);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_prod", out_prod, e[9:2]);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("after_done_valid", out_valid, 0);
    check("after_done_in_ready", in_ready, 1);
  endtask

  initial begin
    int exp_ops[6];
    logic [7:0] ra;
    logic [7:0] rb;
    exp_ops   = '{5, 6, 6, 5, 6, 0};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prod", out_prod, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);

    run_op(8'd3, 8'd5, 0);
    for (int i = 0; i < 6; i++) check($sformatf("op_seq_%0d", i), ops[i], exp_ops[i]);

    run_op(8'd7, 8'd0, 0);
    check("b0_no_alu_op", ops[0], 0);

    run_op(8'd16, 8'd16, 0);
    run_op(8'd250, 8'd1, 0);
    run_op(8'd255, 8'd255, 0);
    run_op(8'd12, 8'd10, 5);

    // reset in the third STEP cycle discards the operation
    in_a      = 8'd9;
    in_b      = 8'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_op_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_out_prod", out_prod, 0);
    check("mid_rst_out_zero", out_zero, 1);
    run_op(8'd2, 8'd3, 0);

    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
